// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encoding,
// opcodes, ALUOp / ALUControl codes, datapath mux selects and a few small
// decode helpers. Imported by aludec and multicycle_controller.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RESULT_ALUOUT    = 2'b00;
    localparam logic [1:0] RESULT_DATA      = 2'b01;
    localparam logic [1:0] RESULT_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format straight from the opcode; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src_dec(input logic [6:0] op);
        case (op)
            OP_LW, OP_I: return IMM_I;
            OP_SW:       return IMM_S;
            OP_BEQ:      return IMM_B;
            OP_JAL:      return IMM_J;
            default:     return IMM_I;
        endcase
    endfunction

    function automatic logic op_known(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
               (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. The controller side uses modport master
// (instruction fields and status in, control strobes/selects out); the
// datapath side uses modport slave.
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       retire;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, retire, illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, retire, illegal
    );

endinterface

// File: rtl/aludec.sv
// ALU decoder: maps ALUOp plus funct3/funct7b5 to the 3-bit ALUControl code.
// Unsupported funct3 values resolve to add so no X ever leaves this block.
module aludec
    import riscv_mc_pkg::*;
(
    input  logic       op5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic [1:0] alu_op_i,
    output logic [2:0] alu_control_o
);

    // ALUControl selection from ALUOp and the instruction function fields.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALU_OP_ADD: alu_control_o = ALU_ADD;
            ALU_OP_SUB: alu_control_o = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3_i)
                    // op[5] separates R-type sub from I-type addi (bit 30 is immediate there)
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-memory multicycle RV32I datapath
// (lw, sw, R-type, I-type ALU, beq, jal). One ALU and one memory port are
// time-shared; FETCH, MEMREAD and MEMWRITE stall on mem_ready.
// Optional feature macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN -- unknown opcodes
// trap into HALT (illegal=1) instead of retiring as a nop.
module multicycle_controller
    import riscv_mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE         = 4'd0,
    parameter bit         MEM_WAIT_EN_DEFAULT = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    multicycle_controller_if.master bus
);

    state_e     state_q, state_d;
    logic       mem_rdy;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       retire;

    // With waiting disabled the memory is assumed to always complete in one cycle.
    assign mem_rdy = MEM_WAIT_EN_DEFAULT ? bus.mem_ready : 1'b1;

    // State register, asynchronously returned to the reset state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= state_e'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_rdy) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = HALT;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR:   state_d = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_rdy) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (mem_rdy) state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            HALT:     state_d = HALT;
`endif
            default:  state_d = FETCH;
        endcase
    end

    // Per-state control outputs; anything not set stays 0 / 00.
    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = RESULT_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        reg_write  = 1'b0;
        alu_op     = ALU_OP_ADD;
        retire     = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RESULT_ALURESULT;
                ir_write   = mem_rdy;
                pc_write   = mem_rdy;
            end
            DECODE: begin
                // Branch target (OldPC + imm) lands in ALUOut for BEQ.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                retire    = !op_known(bus.op);
`endif
            end
            MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = RESULT_DATA;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = mem_rdy;
            end
            EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALU_OP_FUNCT;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALU_OP_SUB;
                pc_write  = bus.Zero;
                retire    = 1'b1;
            end
            JAL: begin
                // PC <- target from ALUOut while the ALU forms OldPC + 4 for rd.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    aludec u_aludec (
        .op5_i         (bus.op[5]),
        .funct3_i      (bus.funct3),
        .funct7b5_i    (bus.funct7b5),
        .alu_op_i      (alu_op),
        .alu_control_o (bus.ALUControl)
    );

    // Strobes are gated by reset_n so nothing is written while reset is held.
    assign bus.PCWrite   = pc_write & reset_n;
    assign bus.MemWrite  = mem_write & reset_n;
    assign bus.IRWrite   = ir_write & reset_n;
    assign bus.RegWrite  = reg_write & reset_n;
    assign bus.retire    = retire & reset_n;
    assign bus.AdrSrc    = adr_src;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ImmSrc    = imm_src_dec(bus.op);

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    // HALT is only left through reset, so this is sticky.
    assign bus.illegal = (state_q == HALT);
`else
    assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: each row is one clock cycle
// of inputs plus the full expected output word. Expected words are queued when
// a row is driven and popped/compared at the following falling edge.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        zero;
        logic        rdy;
        logic [17:0] exp;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [17:0] act;
    vec_t        vecs[$];
    logic [17:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          failures;

    multicycle_controller_if bus_if ();

    multicycle_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb act = {bus_if.PCWrite, bus_if.AdrSrc, bus_if.MemWrite, bus_if.IRWrite,
                       bus_if.ResultSrc, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.RegWrite,
                       bus_if.ImmSrc, bus_if.ALUControl, bus_if.retire, bus_if.illegal};

    // Packs expected outputs in the same order as act.
    function automatic logic [17:0] e(input int pcw, input int adr, input int mw, input int irw,
                                      input int rs, input int sa, input int sb, input int rw,
                                      input int imm, input int aluc, input int ret,
                                      input int ill);
        return {pcw[0], adr[0], mw[0], irw[0], rs[1:0], sa[1:0], sb[1:0], rw[0], imm[1:0],
                aluc[2:0], ret[0], ill[0]};
    endfunction

    function automatic logic [17:0] ef(input int rdy, input int imm);
        return e(rdy, 0, 0, rdy, 2, 0, 2, 0, imm, 0, 0, 0);
    endfunction

    function automatic logic [17:0] ed(input int imm, input int ret);
        return e(0, 0, 0, 0, 0, 1, 1, 0, imm, 0, ret, 0);
    endfunction

    function automatic vec_t mkv(input string n, input int rst, input logic [6:0] op,
                                 input int f3, input int f7, input int z, input int rdy,
                                 input logic [17:0] ex);
        vec_t v;
        v.name  = n;
        v.rst_n = rst[0];
        v.op    = op;
        v.f3    = f3[2:0];
        v.f7    = f7[0];
        v.zero  = z[0];
        v.rdy   = rdy[0];
        v.exp   = ex;
        return v;
    endfunction

    task automatic add(input string n, input int rst, input logic [6:0] op, input int f3,
                       input int f7, input int z, input int rdy, input logic [17:0] ex);
        vecs.push_back(mkv(n, rst, op, f3, f7, z, rdy, ex));
    endtask

    // Four-cycle ALU instruction: FETCH, DECODE, EXECUTER/I, ALUWB.
    task automatic alu_instr(input string n, input logic [6:0] op, input int f3, input int f7,
                             input int sb, input int aluc);
        add({n, "_fetch"}, 1, op, f3, f7, 0, 1, ef(1, 0));
        add({n, "_decode"}, 1, op, f3, f7, 0, 1, ed(0, 0));
        add({n, "_exec"}, 1, op, f3, f7, 0, 1, e(0, 0, 0, 0, 0, 2, sb, 0, 0, aluc, 0, 0));
        add({n, "_wb"}, 1, op, f3, f7, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    endtask

    task automatic check_out();
        logic [17:0] ex;
        string       n;
        ex = exp_q.pop_front();
        n  = name_q.pop_front();
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s: outputs got %05h expected %05h", n, act, ex);
        end
        checks++;
        if ($countones({bus_if.MemWrite, bus_if.RegWrite, bus_if.IRWrite}) > 1) begin
            failures++;
            $display("FAIL %s_strobes: got MemWrite/RegWrite/IRWrite=%b%b%b expected at most one",
                     n, bus_if.MemWrite, bus_if.RegWrite, bus_if.IRWrite);
        end
    endtask

    // Drive one row just after a rising edge, check it at the next falling edge.
    task automatic apply(input vec_t v);
        reset_n          = v.rst_n;
        bus_if.op        = v.op;
        bus_if.funct3    = v.f3;
        bus_if.funct7b5  = v.f7;
        bus_if.Zero      = v.zero;
        bus_if.mem_ready = v.rdy;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [17:0] rst_f;
        checks   = 0;
        failures = 0;
        rst_f    = e(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0, 0);

        reset_n          = 1'b0;
        bus_if.op        = OP_R;
        bus_if.funct3    = 3'b000;
        bus_if.funct7b5  = 1'b0;
        bus_if.Zero      = 1'b0;
        bus_if.mem_ready = 1'b1;

        add("reset", 0, OP_R, 0, 0, 0, 1, rst_f);
        alu_instr("add",     OP_R, 0, 0, 0, 0);
        alu_instr("sub",     OP_R, 0, 1, 0, 1);
        alu_instr("or",      OP_R, 6, 0, 0, 3);
        alu_instr("and",     OP_R, 7, 0, 0, 2);
        alu_instr("slt",     OP_R, 2, 0, 0, 5);
        alu_instr("addi_b30", OP_I, 0, 1, 1, 0);
        alu_instr("xori_add", OP_I, 4, 0, 1, 0);

        add("lw_fetch",  1, OP_LW, 2, 0, 0, 1, ef(1, 0));
        add("lw_decode", 1, OP_LW, 2, 0, 0, 1, ed(0, 0));
        add("lw_memadr", 1, OP_LW, 2, 0, 0, 1, e(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        add("lw_wait1",  1, OP_LW, 2, 0, 0, 0, e(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("lw_wait2",  1, OP_LW, 2, 0, 0, 0, e(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("lw_memrd",  1, OP_LW, 2, 0, 0, 1, e(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("lw_memwb",  1, OP_LW, 2, 0, 0, 1, e(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0));

        add("beqt_fetch",  1, OP_BEQ, 0, 0, 1, 1, ef(1, 2));
        add("beqt_decode", 1, OP_BEQ, 0, 0, 1, 1, ed(2, 0));
        add("beqt_beq",    1, OP_BEQ, 0, 0, 1, 1, e(1, 0, 0, 0, 0, 2, 0, 0, 2, 1, 1, 0));
        add("beqn_fetch",  1, OP_BEQ, 0, 0, 0, 1, ef(1, 2));
        add("beqn_decode", 1, OP_BEQ, 0, 0, 0, 1, ed(2, 0));
        add("beqn_beq",    1, OP_BEQ, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 1, 0));

        add("sw_fetch",  1, OP_SW, 2, 0, 0, 1, ef(1, 1));
        add("sw_decode", 1, OP_SW, 2, 0, 0, 1, ed(1, 0));
        add("sw_memadr", 1, OP_SW, 2, 0, 0, 1, e(0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0));
        add("sw_wait1",  1, OP_SW, 2, 0, 0, 0, e(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add("sw_wait2",  1, OP_SW, 2, 0, 0, 0, e(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        add("sw_done",   1, OP_SW, 2, 0, 0, 1, e(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0));

        add("jal_fstall", 1, OP_JAL, 0, 0, 0, 0, ef(0, 3));
        add("jal_fetch",  1, OP_JAL, 0, 0, 0, 1, ef(1, 3));
        add("jal_decode", 1, OP_JAL, 0, 0, 0, 1, ed(3, 0));
        add("jal_jal",    1, OP_JAL, 0, 0, 0, 1, e(1, 0, 0, 0, 0, 1, 2, 0, 3, 0, 0, 0));
        add("jal_wb",     1, OP_JAL, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0));

        add("bad_fetch", 1, OP_BAD, 0, 0, 0, 1, ef(1, 0));
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        add("bad_decode", 1, OP_BAD, 0, 0, 0, 1, ed(0, 0));
        for (int i = 0; i < 10; i++) begin
            add($sformatf("halt_%0d", i), 1, OP_BAD, 0, 0, 0, 1,
                e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
`else
        add("bad_decode", 1, OP_BAD, 0, 0, 0, 1, ed(0, 1));
        add("bad_refetch", 1, OP_BAD, 0, 0, 0, 1, ef(1, 0));
`endif

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) apply(vecs[i]);

        // Reset clears HALT (or an idle FETCH) and forces every strobe low.
        apply(mkv("rst_clear", 0, OP_R, 0, 0, 0, 1, rst_f));
        // Reset asserted in the middle of EXECUTER: immediate FETCH, no writeback.
        apply(mkv("rx_fetch",    1, OP_R, 0, 0, 0, 1, ef(1, 0)));
        apply(mkv("rx_decode",   1, OP_R, 0, 0, 0, 1, ed(0, 0)));
        apply(mkv("rx_rst_exec", 0, OP_R, 0, 0, 0, 1, rst_f));
        apply(mkv("rx_refetch",  1, OP_R, 0, 0, 0, 1, ef(1, 0)));
        apply(mkv("rx_decode2",  1, OP_R, 0, 0, 0, 1, ed(0, 0)));
        apply(mkv("rx_exec",     1, OP_R, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0)));
        apply(mkv("rx_wb",       1, OP_R, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
